// File: rtl/ff2ff_prbs_pkg.sv
// Shared types and helpers for the FF-to-FF PRBS checker: FSM state
// encoding, the tap table for the supported PRBS orders, and the
// legality test used at elaboration.
package ff2ff_prbs_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEED   = 2'd1,
      VERIFY = 2'd2,
      LOCKED = 2'd3
   } state_t;

   typedef struct packed {
      logic [4:0] tap_a;
      logic [4:0] tap_b;
   } prbs_taps_t;

   // Feedback taps (bit indices into lfsr) for x^N + x^M + 1 generators.
   function automatic prbs_taps_t prbs_taps(input int order);
      prbs_taps_t t;
      case (order)
         32'd7:   begin t.tap_a = 5'd6;  t.tap_b = 5'd5;  end
         32'd9:   begin t.tap_a = 5'd8;  t.tap_b = 5'd4;  end
         32'd15:  begin t.tap_a = 5'd14; t.tap_b = 5'd13; end
         32'd23:  begin t.tap_a = 5'd22; t.tap_b = 5'd17; end
         32'd31:  begin t.tap_a = 5'd30; t.tap_b = 5'd27; end
         default: begin t.tap_a = 5'd0;  t.tap_b = 5'd0;  end
      endcase
      return t;
   endfunction

   // True only for orders that have an entry in the tap table.
   function automatic logic prbs_order_legal(input int order);
      return (order == 32'd7) || (order == 32'd9) || (order == 32'd15) ||
             (order == 32'd23) || (order == 32'd31);
   endfunction

endpackage

// File: rtl/ff2ff_prbs_checker_lfsr.sv
// LFSR core of the PRBS checker. In load mode the register shifts in the
// received bit (self-synchronising seed); in advance mode it free-runs on
// its own feedback. The feedback bit is the next expected received bit.
module prbs_lfsr_core
   import ff2ff_prbs_pkg::*;
#(
   parameter int ORDER = 7
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic advance,
   input  logic data_in,
   output logic expected,
   output logic seed_zero
);

   localparam prbs_taps_t TAPS  = prbs_taps(ORDER);
   localparam int         TAP_A = int'(TAPS.tap_a);
   localparam int         TAP_B = int'(TAPS.tap_b);

   logic [ORDER-1:0] lfsr_r;
   logic [ORDER-1:0] seeded_s;
   logic             fb_s;

   assign fb_s      = lfsr_r[TAP_A] ^ lfsr_r[TAP_B];
   assign seeded_s  = {lfsr_r[ORDER-2:0], data_in};
   assign expected  = fb_s;
   // All-zero would lock the generator up, so the FSM reseeds on it.
   assign seed_zero = (seeded_s == '0);

   // LFSR register: seed from the line, free-run, or hold while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_r <= '0;
      end else if (load) begin
         lfsr_r <= seeded_s;
      end else if (advance) begin
         lfsr_r <= {lfsr_r[ORDER-2:0], fb_s};
      end else begin
         lfsr_r <= lfsr_r;
      end
   end

endmodule

// File: rtl/ff2ff_prbs_checker.sv
// Bit-error checker for the captured data of an FF-to-FF timing path.
// Seeds its LFSR from the incoming stream, verifies LOCK_CNT consecutive
// bits, then counts bits and errors while LOCKED. Too many errors inside
// one WINDOW of bits drop the checker back to seeding.
module ff2ff_prbs_checker
   import ff2ff_prbs_pkg::*;
#(
   parameter int PRBS_ORDER  = 7,
   parameter int CNT_W       = 16,
   parameter int LOCK_CNT    = 32,
   parameter int WINDOW      = 64,
   parameter int LOSS_THRESH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clear,
   input  logic             data_in,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_count
);

   localparam int SEED_W = (PRBS_ORDER > 1) ? $clog2(PRBS_ORDER) : 1;
   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int WERR_W = $clog2(LOSS_THRESH + 1);

   localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(PRBS_ORDER - 1);
   localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
   localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
   localparam logic [WERR_W-1:0] LOSS_LAST = WERR_W'(LOSS_THRESH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   generate
      if (!prbs_order_legal(PRBS_ORDER)) begin : g_bad_order
         $error("ff2ff_prbs_checker: PRBS_ORDER %0d has no tap entry", PRBS_ORDER);
      end
   endgenerate

   state_t            state_r;
   logic [SEED_W-1:0] seed_cnt_r;
   logic [GOOD_W-1:0] good_cnt_r;
   logic [WIN_W-1:0]  win_cnt_r;
   logic [WERR_W-1:0] win_err_r;
   logic              load_s;
   logic              advance_s;
   logic              expected_s;
   logic              seed_zero_s;
   logic              mismatch_s;
   logic              counting_s;

   prbs_lfsr_core #(
      .ORDER (PRBS_ORDER)
   ) u_lfsr (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_s),
      .advance   (advance_s),
      .data_in   (data_in),
      .expected  (expected_s),
      .seed_zero (seed_zero_s)
   );

   assign mismatch_s = data_in ^ expected_s;
   assign counting_s = en && (state_r == LOCKED);

   // LFSR mode select: shift data in while seeding, free-run while checking.
   always_comb begin
      load_s    = 1'b0;
      advance_s = 1'b0;
      if (en && (state_r == SEED)) begin
         load_s = 1'b1;
      end else if (en && ((state_r == VERIFY) || (state_r == LOCKED))) begin
         advance_s = 1'b1;
      end else begin
         load_s    = 1'b0;
         advance_s = 1'b0;
      end
   end

   // Sync FSM with its counters; locked is set on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         seed_cnt_r <= '0;
         good_cnt_r <= '0;
         win_cnt_r  <= '0;
         win_err_r  <= '0;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
      end else begin
         err_pulse <= 1'b0;
         if (!en) begin
            state_r <= IDLE;
            locked  <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  state_r    <= SEED;
                  seed_cnt_r <= '0;
                  locked     <= 1'b0;
               end
               SEED: begin
                  locked <= 1'b0;
                  if (seed_cnt_r == SEED_LAST) begin
                     seed_cnt_r <= '0;
                     if (seed_zero_s) begin
                        state_r <= SEED;
                     end else begin
                        state_r    <= VERIFY;
                        good_cnt_r <= '0;
                     end
                  end else begin
                     seed_cnt_r <= seed_cnt_r + 1'b1;
                  end
               end
               VERIFY: begin
                  if (mismatch_s) begin
                     state_r    <= SEED;
                     seed_cnt_r <= '0;
                     locked     <= 1'b0;
                  end else if (good_cnt_r == GOOD_LAST) begin
                     state_r   <= LOCKED;
                     win_cnt_r <= '0;
                     win_err_r <= '0;
                     locked    <= 1'b1;
                  end else begin
                     good_cnt_r <= good_cnt_r + 1'b1;
                     locked     <= 1'b0;
                  end
               end
               LOCKED: begin
                  err_pulse <= mismatch_s;
                  if (mismatch_s && (win_err_r >= LOSS_LAST)) begin
                     // This error completes the loss threshold: resync.
                     state_r    <= SEED;
                     seed_cnt_r <= '0;
                     locked     <= 1'b0;
                  end else if (win_cnt_r == WIN_LAST) begin
                     win_cnt_r <= '0;
                     win_err_r <= '0;
                     locked    <= 1'b1;
                  end else begin
                     win_cnt_r <= win_cnt_r + 1'b1;
                     win_err_r <= win_err_r + {{(WERR_W-1){1'b0}}, mismatch_s};
                     locked    <= 1'b1;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  locked  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Saturating bit/error counters; clear overrides a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
         bit_count <= '0;
      end else if (clear) begin
         err_count <= '0;
         bit_count <= '0;
      end else if (counting_s) begin
         if (bit_count != CNT_MAX) begin
            bit_count <= bit_count + 1'b1;
         end
         if (mismatch_s && (err_count != CNT_MAX)) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ff2ff_prbs_checker.sv
// Self-checking bench for ff2ff_prbs_checker. A queue-based model of the
// checking rules runs alongside the main instance and is compared every
// cycle; a scenario table plus directed sequences cover lock latency,
// error injection, loss of lock, all-zero seed, async reset and, on a
// narrow-counter instance, saturation and clear priority.
module tb_ff2ff_prbs_checker;

   localparam int ORDER    = 7;
   localparam int LOCK_N   = 32;
   localparam int WIN_N    = 64;
   localparam int LOSS_N   = 4;
   localparam int CNT_MAX  = 65535;
   localparam int PH_IDLE  = 0;
   localparam int PH_SEED  = 1;
   localparam int PH_VER   = 2;
   localparam int PH_LOCK  = 3;

   logic        clk = 1'b0;
   logic        rst_n, en, clear, data_in;
   logic        locked, err_pulse;
   logic [15:0] err_count, bit_count;
   logic        s_en, s_clear, s_data;
   logic        s_locked, s_err_pulse;
   logic [3:0]  s_err_count, s_bit_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ff2ff_prbs_checker dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .data_in(data_in),
      .locked(locked), .err_pulse(err_pulse),
      .err_count(err_count), .bit_count(bit_count)
   );

   ff2ff_prbs_checker #(.CNT_W(4), .LOSS_THRESH(40)) dut_s (
      .clk(clk), .rst_n(rst_n), .en(s_en), .clear(s_clear), .data_in(s_data),
      .locked(s_locked), .err_pulse(s_err_pulse),
      .err_count(s_err_count), .bit_count(s_bit_count)
   );

   // ---------------- upstream PRBS7 source: b[n] = b[n-7] ^ b[n-6]
   logic src_q[$];

   task automatic next_src(output logic b);
      b = src_q[0] ^ src_q[1];
      src_q.push_back(b);
      void'(src_q.pop_front());
   endtask

   // ---------------- reference model
   int   m_phase, m_seed_n, m_good, m_win_pos, m_win_errs, m_errs, m_bits;
   logic m_locked, m_pulse;
   logic m_hist[$];

   task automatic model_reset();
      m_phase = PH_IDLE; m_seed_n = 0; m_good = 0; m_win_pos = 0;
      m_win_errs = 0; m_errs = 0; m_bits = 0; m_locked = 1'b0; m_pulse = 1'b0;
      m_hist.delete();
   endtask

   task automatic model_update();
      logic exp_b;
      logic err;
      bit   nonzero;
      if (!rst_n) begin
         model_reset();
         return;
      end
      m_pulse = 1'b0;
      if (!en) begin
         m_phase = PH_IDLE;
      end else if (m_phase == PH_IDLE) begin
         m_phase  = PH_SEED;
         m_seed_n = 0;
      end else if (m_phase == PH_SEED) begin
         m_hist.push_back(data_in);
         if (m_hist.size() > ORDER) void'(m_hist.pop_front());
         m_seed_n++;
         if (m_seed_n == ORDER) begin
            m_seed_n = 0;
            nonzero  = 1'b0;
            foreach (m_hist[i]) if (m_hist[i]) nonzero = 1'b1;
            if (nonzero) begin
               m_phase = PH_VER;
               m_good  = 0;
            end
         end
      end else begin
         // predicted sequence continues from the seeded history
         exp_b = m_hist[0] ^ m_hist[1];
         m_hist.push_back(exp_b);
         void'(m_hist.pop_front());
         err = (data_in !== exp_b);
         if (m_phase == PH_VER) begin
            if (err) begin
               m_phase  = PH_SEED;
               m_seed_n = 0;
            end else begin
               m_good++;
               if (m_good == LOCK_N) begin
                  m_phase = PH_LOCK; m_win_pos = 0; m_win_errs = 0;
               end
            end
         end else begin
            if (m_bits < CNT_MAX) m_bits++;
            if (err) begin
               m_pulse = 1'b1;
               if (m_errs < CNT_MAX) m_errs++;
               m_win_errs++;
            end
            if (err && (m_win_errs >= LOSS_N)) begin
               m_phase  = PH_SEED;
               m_seed_n = 0;
            end else if (m_win_pos == WIN_N - 1) begin
               m_win_pos  = 0;
               m_win_errs = 0;
            end else begin
               m_win_pos++;
            end
         end
      end
      if (clear) begin
         m_errs = 0;
         m_bits = 0;
      end
      m_locked = (m_phase == PH_LOCK);
   endtask

   // ---------------- checking helpers
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check("model_locked",    32'(locked),    32'(m_locked));
      check("model_err_pulse", 32'(err_pulse), 32'(m_pulse));
      check("model_err_count", 32'(err_count), 32'(m_errs));
      check("model_bit_count", 32'(bit_count), 32'(m_bits));
   endtask

   task automatic bit_step(input logic flip);
      logic b;
      next_src(b);
      data_in = b ^ flip;
      s_data  = b ^ flip;
      step();
   endtask

   task automatic wait_lock(input int limit, output int cycles);
      cycles = 0;
      while (!locked && cycles < limit) begin
         bit_step(1'b0);
         cycles++;
      end
      check("lock_within_bound", 32'(locked), 32'd1);
   endtask

   typedef struct {
      string name;
      int    n_err;
      int    gap;
      int    exp_cnt;
      logic  exp_locked;
   } row_t;

   row_t rows[5];

   initial begin
      int   c;
      bit   any_lock;
      logic flip;

      rows[0] = '{"single_error",       1, 1,  1, 1'b1};
      rows[1] = '{"three_spaced",       3, 5,  3, 1'b1};
      rows[2] = '{"four_in_window",     4, 3,  4, 1'b0};
      rows[3] = '{"four_across_windows",4, 70, 4, 1'b1};
      rows[4] = '{"four_back_to_back",  4, 1,  4, 1'b0};

      src_q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      rst_n = 1'b0; en = 1'b0; clear = 1'b0; data_in = 1'b0;
      s_en = 1'b0; s_clear = 1'b0; s_data = 1'b0;
      model_reset();

      // reset state
      #2;
      check("rst_locked",    32'(locked),    32'd0);
      check("rst_err_pulse", 32'(err_pulse), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_bit_count", 32'(bit_count), 32'd0);
      check("rst_s_err_count", 32'(s_err_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // first lock from cycle 0 of enable: 1 (IDLE) + 7 (seed) + 32 (verify)
      en = 1'b1;
      wait_lock(60, c);
      check("lock_latency", 32'(c), 32'd40);
      check("lock_err_count", 32'(err_count), 32'd0);
      check("lock_bit_count", 32'(bit_count), 32'd0);
      for (int i = 0; i < 10; i++) bit_step(1'b0);
      check("bit_count_rate", 32'(bit_count), 32'd10);
      check("clean_err_count", 32'(err_count), 32'd0);

      // table-driven error scenarios, each from a fresh lock (window at 0)
      for (int r = 0; r < 5; r++) begin
         en = 1'b0;
         bit_step(1'b0);
         en = 1'b1;
         wait_lock(60, c);
         check({rows[r].name, "_relock"}, 32'(c), 32'd40);
         clear = 1'b1;
         bit_step(1'b0);
         clear = 1'b0;
         for (int i = 0; i <= (rows[r].n_err - 1) * rows[r].gap + 3; i++) begin
            flip = ((i % rows[r].gap) == 0) && ((i / rows[r].gap) < rows[r].n_err);
            bit_step(flip);
            if (flip) check({rows[r].name, "_pulse"}, 32'(err_pulse), 32'd1);
         end
         check({rows[r].name, "_err_count"}, 32'(err_count), 32'(rows[r].exp_cnt));
         check({rows[r].name, "_locked"}, 32'(locked), 32'(rows[r].exp_locked));
         if (!rows[r].exp_locked) begin
            wait_lock(45, c);
            check({rows[r].name, "_count_after_resync"}, 32'(err_count), 32'(rows[r].exp_cnt));
         end
      end

      // clear in the same cycle as an error on the wide instance
      bit_step(1'b1);
      clear = 1'b1;
      bit_step(1'b1);
      clear = 1'b0;
      check("clear_vs_err", 32'(err_count), 32'd0);

      // constant-zero stream never seeds past SEED
      en = 1'b0; clear = 1'b1;
      bit_step(1'b0);
      en = 1'b1; clear = 1'b0;
      any_lock = 1'b0;
      data_in = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (locked) any_lock = 1'b1;
      end
      check("zero_never_locks", 32'(any_lock), 32'd0);
      check("zero_err_count",   32'(err_count), 32'd0);
      check("zero_bit_count",   32'(bit_count), 32'd0);

      // asynchronous reset between edges while LOCKED
      wait_lock(60, c);
      bit_step(1'b1);
      for (int i = 0; i < 3; i++) bit_step(1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_locked",    32'(locked),    32'd0);
      check("arst_err_count", 32'(err_count), 32'd0);
      check("arst_bit_count", 32'(bit_count), 32'd0);
      model_reset();
      step();
      rst_n = 1'b1;
      wait_lock(60, c);
      check("arst_relock", 32'(c), 32'd40);

      // randomized stream against the model
      for (int i = 0; i < 2000; i++) begin
         en    = ($urandom_range(0, 299) != 0);
         clear = ($urandom_range(0, 149) == 0);
         bit_step($urandom_range(0, 79) == 0);
      end
      en = 1'b0; clear = 1'b0;
      bit_step(1'b0);

      // narrow-counter instance: saturation and clear priority
      s_en = 1'b1;
      c = 0;
      while (!s_locked && c < 60) begin
         bit_step(1'b0);
         c++;
      end
      check("sat_locked", 32'(s_locked), 32'd1);
      for (int i = 0; i < 20; i++) bit_step(1'b1);
      check("sat_err_count", 32'(s_err_count), 32'd15);
      check("sat_bit_count", 32'(s_bit_count), 32'd15);
      check("sat_still_locked", 32'(s_locked), 32'd1);
      s_clear = 1'b1;
      bit_step(1'b1);
      s_clear = 1'b0;
      check("sat_clear_wins", 32'(s_err_count), 32'd0);
      check("sat_clear_bits", 32'(s_bit_count), 32'd0);
      bit_step(1'b1);
      check("sat_count_resume", 32'(s_err_count), 32'd1);
      bit_step(1'b0);
      check("sat_pulse_drop", 32'(s_err_pulse), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
